rx_word_align_ctrl: RTL
=======================

# rx_word_align_ctrl

Word-alignment controller that sits directly downstream of the RX IOD bit-alignment core in the video receive lane. Once bit alignment reports done, it compares the deserialized parallel word against a fixed training pattern and issues single-cycle BITSLIP pulses to the IOD until the word boundary locks. If all slip positions are exhausted, or the bit aligner reports an error, it pulses BIT_ALGN_RSTRT back to the bit aligner and retries, up to a bounded retry count. One controller is instantiated per data lane.

## Interface
- DATA_WIDTH, 10: deserializer ratio and RX_DATA width; legal range 4..16.
- TRAIN_PATTERN, 10'h3E0: training word, DATA_WIDTH bits; all DATA_WIDTH rotations must be distinct.
- MATCH_CNT, 8: consecutive matching words required to declare lock; legal range 2..255.
- SLIP_WAIT, 4: settle cycles after each BITSLIP before comparing again; legal range 1..15.
- MAX_RETRY, 3: bit-aligner restarts allowed before FAIL; legal range 0..15.

Ports:
- SCLK  in  1  fabric clock; all logic is on this one clock.
- RESET  in  1  asynchronous, active-high reset.
- BIT_ALGN_DONE  in  1  level input from the bit aligner.
- BIT_ALGN_ERR  in  1  level input from the bit aligner.
- RX_DATA  in  DATA_WIDTH  parallel word from the IOD, valid every cycle.
- BITSLIP  out  1  one-cycle pulse to the IOD; rotates RX_DATA by one bit.
- BIT_ALGN_RSTRT  out  1  one-cycle restart pulse to the bit aligner.
- WORD_ALGN_DONE  out  1  lane word-locked.
- WORD_ALGN_ERR  out  1  sticky failure flag.
- SLIP_CNT  out  4  number of slips issued in the current attempt.
- RETRY_CNT  out  4  number of restarts issued since RESET.

## Operation
States: IDLE, CHECK, SLIP, WAIT, LOCKED, RESTART, DROP, FAIL.

- **IDLE**
  - BIT_ALGN_ERR=1 → RESTART; this takes priority over DONE.
  - Otherwise, BIT_ALGN_DONE=1 → CHECK, clearing match_cnt and SLIP_CNT.
- **CHECK**
  - RX_DATA==TRAIN_PATTERN: match_cnt+1. When it reaches MATCH_CNT → LOCKED.
  - Mismatch: match_cnt cleared. If SLIP_CNT==DATA_WIDTH-1 → RESTART (all positions tried); otherwise → SLIP.
- **SLIP**: BITSLIP=1 for exactly this cycle; SLIP_CNT+1; → WAIT.
- **WAIT**: count SLIP_WAIT cycles, ignoring RX_DATA; → CHECK.
- **LOCKED**
  - WORD_ALGN_DONE=1. RX_DATA is no longer checked.
  - BIT_ALGN_DONE falling → IDLE and DONE clears.
  - BIT_ALGN_ERR=1 → RESTART.
- **RESTART**
  - If RETRY_CNT==MAX_RETRY → FAIL.
  - Otherwise: BIT_ALGN_RSTRT=1 for this cycle, RETRY_CNT+1, SLIP_CNT cleared; → DROP.
- **DROP**: wait for BIT_ALGN_DONE=0, so stale DONE is not consumed; → IDLE.
- **FAIL**: WORD_ALGN_ERR=1, all pulse outputs 0; remains until RESET.
- **Global rules**
  - BIT_ALGN_DONE dropping in CHECK, SLIP or WAIT → IDLE, clearing match_cnt and SLIP_CNT; no retry is consumed.
  - BIT_ALGN_ERR=1 in CHECK, SLIP or WAIT → RESTART.
- **Arithmetic**
  - match_cnt is 8 bits; SLIP_CNT, RETRY_CNT and the wait counter are 4 bits.
  - Counters saturate rather than wrap; reachable values never exceed their limits.

## Timing
- RESET asserted, asynchronously:
  - state=IDLE.
  - BITSLIP=0, BIT_ALGN_RSTRT=0, WORD_ALGN_DONE=0, WORD_ALGN_ERR=0, SLIP_CNT=0, RETRY_CNT=0.
  - All outputs are registered.
- RESET mid-operation aborts immediately. A BITSLIP or RSTRT pulse in flight is truncated.
- IDLE→CHECK: 1 cycle after BIT_ALGN_DONE is sampled high. RX_DATA is first compared in the CHECK cycle.
- Per mismatch: CHECK (1) + SLIP (1) + WAIT (SLIP_WAIT) = 6 cycles with defaults, between consecutive comparisons.
- BITSLIP spacing is never less than SLIP_WAIT+2 cycles.
- WORD_ALGN_DONE rises on the clock edge that samples the MATCH_CNT-th consecutive match. It is high in the following cycle.
- BIT_ALGN_RSTRT is exactly 1 cycle wide, and RSTRT pulses are at least 3 cycles apart.
- Simultaneous ERR and DONE drop in CHECK: ERR wins, giving RESTART.

## Test plan
- Bit aligner done, RX_DATA=TRAIN_PATTERN constantly → no BITSLIP; WORD_ALGN_DONE=1 on the 9th cycle after DONE sampled; SLIP_CNT=0.
- Lane model rotates right by 3 and rotates one bit per BITSLIP → exactly 3 BITSLIP pulses, each 6 cycles apart; then lock with SLIP_CNT=3, RETRY_CNT=0.
- Pattern never matches → 9 slips, then RSTRT pulse and RETRY_CNT=1. The model drops and re-raises DONE; after the 4th exhaustion, FAIL with WORD_ALGN_ERR=1, RETRY_CNT=3, no further RSTRT.
- BIT_ALGN_ERR=1 while in WAIT → RSTRT pulse next cycle; DROP holds until DONE=0; then IDLE.
- Match run of 7, then one mismatch → match_cnt resets, one BITSLIP, no DONE. The following 8 matches lock.
- RESET asserted mid-SLIP → BITSLIP falls asynchronously; all outputs at reset values; the sequence restarts cleanly after release.

Source files
------------

// File: rtl/rx_word_align_ctrl.sv
// Per-lane word aligner: compares the deserialized word against a training pattern,
// slips the IOD until the boundary locks, and restarts the bit aligner when exhausted.
module rx_word_align_ctrl #(
    parameter int                    DATA_WIDTH    = 10,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 10'h3E0,
    parameter int                    MATCH_CNT     = 8,
    parameter int                    SLIP_WAIT     = 4,
    parameter int                    MAX_RETRY     = 3
) (
    input  logic                  SCLK,
    input  logic                  RESET,
    input  logic                  BIT_ALGN_DONE,
    input  logic                  BIT_ALGN_ERR,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  BITSLIP,
    output logic                  BIT_ALGN_RSTRT,
    output logic                  WORD_ALGN_DONE,
    output logic                  WORD_ALGN_ERR,
    output logic [3:0]            SLIP_CNT,
    output logic [3:0]            RETRY_CNT
);
    localparam logic [3:0] SLIP_LAST  = 4'(DATA_WIDTH - 1);
    localparam logic [7:0] MATCH_LAST = 8'(MATCH_CNT - 1);
    localparam logic [3:0] WAIT_LAST  = 4'(SLIP_WAIT - 1);
    localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SLIP, S_WAIT, S_LOCKED, S_RESTART, S_DROP, S_FAIL
    } state_t;

    state_t     state;
    logic [7:0] match_cnt;
    logic [3:0] wait_cnt;
    logic       pattern_hit;
    logic       in_search;
    logic       err_req;
    logic       drop_req;
    logic       exhaust_req;
    logic       restart_req;

    // An aligner error outranks a DONE drop; a DONE drop outranks slip exhaustion,
    // since the word is meaningless once the bit aligner has let go.
    always_comb begin
        pattern_hit = (RX_DATA == TRAIN_PATTERN);
        in_search   = (state == S_CHECK) || (state == S_SLIP) || (state == S_WAIT);
        err_req     = BIT_ALGN_ERR && (in_search || state == S_IDLE || state == S_LOCKED);
        drop_req    = !BIT_ALGN_DONE && (in_search || state == S_LOCKED);
        exhaust_req = (state == S_CHECK) && !pattern_hit && (SLIP_CNT == SLIP_LAST);
        restart_req = err_req || (exhaust_req && !drop_req);
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state          <= S_IDLE;
            match_cnt      <= 8'd0;
            wait_cnt       <= 4'd0;
            BITSLIP        <= 1'b0;
            BIT_ALGN_RSTRT <= 1'b0;
            WORD_ALGN_DONE <= 1'b0;
            WORD_ALGN_ERR  <= 1'b0;
            SLIP_CNT       <= 4'd0;
            RETRY_CNT      <= 4'd0;
        end else begin
            BITSLIP        <= 1'b0;
            BIT_ALGN_RSTRT <= 1'b0;
            if (restart_req) begin
                // The retry budget is judged on entry so the pulse lines up with RESTART.
                state          <= S_RESTART;
                match_cnt      <= 8'd0;
                SLIP_CNT       <= 4'd0;
                WORD_ALGN_DONE <= 1'b0;
                if (RETRY_CNT != RETRY_MAX) begin
                    BIT_ALGN_RSTRT <= 1'b1;
                    RETRY_CNT      <= RETRY_CNT + 4'd1;
                end
            end else if (drop_req) begin
                state          <= S_IDLE;
                match_cnt      <= 8'd0;
                SLIP_CNT       <= 4'd0;
                WORD_ALGN_DONE <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (BIT_ALGN_DONE) begin
                            state     <= S_CHECK;
                            match_cnt <= 8'd0;
                            SLIP_CNT  <= 4'd0;
                        end
                    end
                    S_CHECK: begin
                        if (pattern_hit) begin
                            if (match_cnt != 8'hFF)
                                match_cnt <= match_cnt + 8'd1;
                            if (match_cnt == MATCH_LAST) begin
                                state          <= S_LOCKED;
                                WORD_ALGN_DONE <= 1'b1;
                            end
                        end else begin
                            match_cnt <= 8'd0;
                            state     <= S_SLIP;
                            BITSLIP   <= 1'b1;
                            if (SLIP_CNT != 4'hF)
                                SLIP_CNT <= SLIP_CNT + 4'd1;
                        end
                    end
                    S_SLIP: begin
                        state    <= S_WAIT;
                        wait_cnt <= 4'd0;
                    end
                    S_WAIT: begin
                        if (wait_cnt == WAIT_LAST)
                            state <= S_CHECK;
                        else
                            wait_cnt <= wait_cnt + 4'd1;
                    end
                    S_LOCKED: begin
                        WORD_ALGN_DONE <= 1'b1;
                    end
                    S_RESTART: begin
                        if (BIT_ALGN_RSTRT) begin
                            state <= S_DROP;
                        end else begin
                            state         <= S_FAIL;
                            WORD_ALGN_ERR <= 1'b1;
                        end
                    end
                    S_DROP: begin
                        if (!BIT_ALGN_DONE)
                            state <= S_IDLE;
                    end
                    S_FAIL: begin
                        WORD_ALGN_ERR <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
